max7219_serial_rx: RTL and testbench
====================================

Name: max7219_serial_rx

Overview:
- Receive-side model of the 3-wire serial display link driven by the clock core (load/CS, dout/MOSI, sck).
- Oversamples the three lines in the i_clk domain, shifts in 16-bit MSB-first frames and commits them on the rising edge of load into a MAX7219-style register file.
- Exposes the decoded digit and control registers for on-chip loopback self-test and for scoreboarding in the verification bench.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops per serial input (minimum 2)
FRAME_BITS, 16, bits per frame; address is bits [11:8], data is bits [7:0], bits [15:12] are ignored

Ports:
i_clk  input  1  system clock, must be at least 4x the sck frequency
i_reset_n  input  1  synchronous active-low reset
i_serial_clk  input  1  sck from transmitter, asynchronous to i_clk
i_serial_dout  input  1  serial data (MOSI), sampled on sck rising edge
i_serial_load  input  1  load/CS: low during shifting, rising edge commits the frame
o_digits  output  64  digit registers 0..7 packed; digit n is at [8n+7:8n]
o_decode_mode  output  8  decode-mode register
o_intensity  output  4  intensity register
o_scan_limit  output  3  scan-limit register
o_shutdown_n  output  1  0 = shutdown, 1 = normal operation
o_display_test  output  1  display-test flag
o_wr_valid  output  1  one-cycle pulse for each committed frame
o_wr_addr  output  4  address of the committed frame; valid with o_wr_valid
o_wr_data  output  8  data of the committed frame; valid with o_wr_valid
o_frame_err  output  1  one-cycle pulse when a frame is short (fewer than FRAME_BITS bits)

Behaviour:
- Reset, applied on the i_clk edge while i_reset_n is low:
  - all registers, o_digits, o_decode_mode and o_intensity = 0
  - o_scan_limit = 0, o_shutdown_n = 0, o_display_test = 0
  - o_wr_valid = 0, o_frame_err = 0, shift register = 0, bit count = 0
  - synchronizer flops cleared to 0
- Synchronization and edge detection:
  - Each input passes through SYNC_STAGES flops plus one history flop.
  - An edge is flagged when the last synchronizer flop differs from the history flop in the required direction.
- Shifting:
  - On a synchronized sck rising edge while synchronized load is low: shift register <= {sr[14:0], dout_sync}.
  - dout is taken from the same synchronizer depth as sck.
  - Bit count increments and saturates at FRAME_BITS.
  - sck edges while load is high are ignored.
- Load falling edge: bit count cleared to 0; shift register contents kept.
- Load rising edge, count == FRAME_BITS: commit the last 16 bits shifted in, so a longer frame keeps its trailing 16 bits.
- Load rising edge, count < FRAME_BITS: no register update, o_frame_err pulses for 1 cycle.
- Latency:
  - o_wr_valid, o_wr_addr/o_wr_data and the target register update together.
  - This happens SYNC_STAGES+1 i_clk edges after the first edge that samples load high.
  - o_wr_valid is high for exactly 1 cycle.
- Address decode on commit:
  - 0x0: no-op; o_wr_valid still pulses.
  - 0x1..0x8: digit 0..7 <= data.
  - 0x9: decode <= data.
  - 0xA: intensity <= data[3:0].
  - 0xB: scan_limit <= data[2:0].
  - 0xC: shutdown_n <= data[0].
  - 0xF: display_test <= data[0].
  - 0xD, 0xE: ignored; o_wr_valid still pulses.
- Simultaneous events: an sck rising edge detected in the same cycle as a load rising edge is ignored. The frame is evaluated with the prior count and shift contents.
- Reset while a frame is in flight: the partial frame is discarded and the next frame starts from count 0.
- Back-to-back frames: any load-high time of at least 2 i_clk cycles yields an independent commit.

Decomposition:
- Package max7219_pkg holds:
  - address constants ADDR_NOOP, ADDR_DIGIT0..7, ADDR_DECODE, ADDR_INTENSITY, ADDR_SCAN_LIMIT, ADDR_SHUTDOWN, ADDR_DISPLAY_TEST
  - FRAME_BITS default
  - register reset values
- Sub-module serial_sync_edge (parameter SYNC_STAGES; outputs level, rise, fall) is instantiated for sck, dout and load. For dout only the level output is used.

Test Plan:
- Reset: hold i_reset_n low 2 cycles -> all outputs 0, no o_wr_valid.
- Frame 0x0C01 sent with sck = i_clk/8 -> o_wr_valid pulse with addr 0xC, data 0x01; o_shutdown_n = 1 exactly SYNC_STAGES+1 cycles after load rises.
- Frames 0x0112, then 0x08A5, then 0x0A3F -> digit0 = 0x12, digit7 = 0xA5, o_intensity = 0xF; other digits remain 0.
- Short frame of 12 bits, then load high -> o_frame_err 1-cycle pulse; no register change and no o_wr_valid.
- Long frame of 20 bits, 0xF_0B07 -> last 16 bits 0x0B07 commit, o_scan_limit = 7; 0xDxx frame -> o_wr_valid pulses, no register change.
- sck toggling while load is high, then assert i_reset_n low mid-frame after 8 bits -> no commits; a subsequent full frame 0x0F01 sets o_display_test = 1.

Source files
------------

// File: rtl/max7219_pkg.sv
// Shared constants and types for the MAX7219-style serial receiver.
package max7219_pkg;

    localparam int unsigned FRAME_BITS_DEF = 16;
    localparam int unsigned ADDR_W         = 4;
    localparam int unsigned DATA_W         = 8;

    localparam logic [ADDR_W-1:0] ADDR_NOOP         = 4'h0;
    localparam logic [ADDR_W-1:0] ADDR_DIGIT0       = 4'h1;
    localparam logic [ADDR_W-1:0] ADDR_DIGIT1       = 4'h2;
    localparam logic [ADDR_W-1:0] ADDR_DIGIT2       = 4'h3;
    localparam logic [ADDR_W-1:0] ADDR_DIGIT3       = 4'h4;
    localparam logic [ADDR_W-1:0] ADDR_DIGIT4       = 4'h5;
    localparam logic [ADDR_W-1:0] ADDR_DIGIT5       = 4'h6;
    localparam logic [ADDR_W-1:0] ADDR_DIGIT6       = 4'h7;
    localparam logic [ADDR_W-1:0] ADDR_DIGIT7       = 4'h8;
    localparam logic [ADDR_W-1:0] ADDR_DECODE       = 4'h9;
    localparam logic [ADDR_W-1:0] ADDR_INTENSITY    = 4'hA;
    localparam logic [ADDR_W-1:0] ADDR_SCAN_LIMIT   = 4'hB;
    localparam logic [ADDR_W-1:0] ADDR_SHUTDOWN     = 4'hC;
    localparam logic [ADDR_W-1:0] ADDR_DISPLAY_TEST = 4'hF;

    localparam logic [63:0] RST_DIGITS       = 64'h0;
    localparam logic [7:0]  RST_DECODE       = 8'h00;
    localparam logic [3:0]  RST_INTENSITY    = 4'h0;
    localparam logic [2:0]  RST_SCAN_LIMIT   = 3'h0;
    localparam logic        RST_SHUTDOWN_N   = 1'b0;
    localparam logic        RST_DISPLAY_TEST = 1'b0;

    // One decoded register write taken from a completed frame.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/serial_sync_edge.sv
// Multi-flop synchronizer with a history flop for edge detection.
module serial_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Shift the asynchronous input through the synchronizer chain and keep one sample of history.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level  = r_sync[SYNC_STAGES-1];
    assign o_rise_c =  r_sync[SYNC_STAGES-1] & ~r_hist;
    assign o_fall_c = ~r_sync[SYNC_STAGES-1] &  r_hist;

endmodule

// File: rtl/max7219_serial_rx.sv
// Receive side of the 3-wire display link: oversampled shift-in, commit on load rise, register file.
module max7219_serial_rx
    import max7219_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FRAME_BITS  = FRAME_BITS_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_serial_clk,
    input  logic        i_serial_dout,
    input  logic        i_serial_load,
    output logic [63:0] o_digits,
    output logic [7:0]  o_decode_mode,
    output logic [3:0]  o_intensity,
    output logic [2:0]  o_scan_limit,
    output logic        o_shutdown_n,
    output logic        o_display_test,
    output logic        o_wr_valid,
    output logic [3:0]  o_wr_addr,
    output logic [7:0]  o_wr_data,
    output logic        o_frame_err
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

    logic w_sck_level_unused;
    logic w_sck_rise;
    logic w_sck_fall_unused;
    logic w_dout_level;
    logic w_dout_rise_unused;
    logic w_dout_fall_unused;
    logic w_load_level;
    logic w_load_rise;
    logic w_load_fall;
    logic w_shift;
    logic w_frame_full;
    logic w_sr_hi_unused;

    logic [FRAME_BITS-1:0] r_sr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_req_valid;
    wr_req_t               r_req;
    logic                  r_err_pend;

    logic [63:0] r_digits;
    logic [7:0]  r_decode_mode;
    logic [3:0]  r_intensity;
    logic [2:0]  r_scan_limit;
    logic        r_shutdown_n;
    logic        r_display_test;
    logic        r_wr_valid;
    logic [3:0]  r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        r_frame_err;

    serial_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_async   (i_serial_clk),
        .o_level   (w_sck_level_unused),
        .o_rise_c  (w_sck_rise),
        .o_fall_c  (w_sck_fall_unused)
    );

    serial_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dout (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_async   (i_serial_dout),
        .o_level   (w_dout_level),
        .o_rise_c  (w_dout_rise_unused),
        .o_fall_c  (w_dout_fall_unused)
    );

    serial_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_async   (i_serial_load),
        .o_level   (w_load_level),
        .o_rise_c  (w_load_rise),
        .o_fall_c  (w_load_fall)
    );

    // A load rise already shows level high, so a coincident sck rise is dropped here too.
    assign w_shift        = w_sck_rise & ~w_load_level;
    assign w_frame_full   = (r_cnt == CNT_W'(FRAME_BITS));
    assign w_sr_hi_unused = ^r_sr[FRAME_BITS-1:12];

    // Shift register and saturating bit counter; load fall restarts the count.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (w_load_fall) begin
            r_cnt <= '0;
        end else if (w_shift) begin
            r_sr <= {r_sr[FRAME_BITS-2:0], w_dout_level};
            if (!w_frame_full) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Evaluate the frame on load rise: queue a write for a full frame, an error otherwise.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_req_valid <= 1'b0;
            r_req       <= '0;
            r_err_pend  <= 1'b0;
        end else begin
            r_req_valid <= w_load_rise & w_frame_full;
            r_err_pend  <= w_load_rise & ~w_frame_full;
            if (w_load_rise & w_frame_full) begin
                r_req.addr <= r_sr[11:8];
                r_req.data <= r_sr[7:0];
            end
        end
    end

    // Register file update, write strobe and error strobe all land on the same edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_digits       <= RST_DIGITS;
            r_decode_mode  <= RST_DECODE;
            r_intensity    <= RST_INTENSITY;
            r_scan_limit   <= RST_SCAN_LIMIT;
            r_shutdown_n   <= RST_SHUTDOWN_N;
            r_display_test <= RST_DISPLAY_TEST;
            r_wr_valid     <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_frame_err    <= 1'b0;
        end else begin
            r_wr_valid  <= r_req_valid;
            r_frame_err <= r_err_pend;
            if (r_req_valid) begin
                r_wr_addr <= r_req.addr;
                r_wr_data <= r_req.data;
                case (r_req.addr)
                    ADDR_NOOP:         ;
                    ADDR_DIGIT0:       r_digits[7:0]   <= r_req.data;
                    ADDR_DIGIT1:       r_digits[15:8]  <= r_req.data;
                    ADDR_DIGIT2:       r_digits[23:16] <= r_req.data;
                    ADDR_DIGIT3:       r_digits[31:24] <= r_req.data;
                    ADDR_DIGIT4:       r_digits[39:32] <= r_req.data;
                    ADDR_DIGIT5:       r_digits[47:40] <= r_req.data;
                    ADDR_DIGIT6:       r_digits[55:48] <= r_req.data;
                    ADDR_DIGIT7:       r_digits[63:56] <= r_req.data;
                    ADDR_DECODE:       r_decode_mode   <= r_req.data;
                    ADDR_INTENSITY:    r_intensity     <= r_req.data[3:0];
                    ADDR_SCAN_LIMIT:   r_scan_limit    <= r_req.data[2:0];
                    ADDR_SHUTDOWN:     r_shutdown_n    <= r_req.data[0];
                    ADDR_DISPLAY_TEST: r_display_test  <= r_req.data[0];
                    default:           ;
                endcase
            end
        end
    end

    assign o_digits       = r_digits;
    assign o_decode_mode  = r_decode_mode;
    assign o_intensity    = r_intensity;
    assign o_scan_limit   = r_scan_limit;
    assign o_shutdown_n   = r_shutdown_n;
    assign o_display_test = r_display_test;
    assign o_wr_valid     = r_wr_valid;
    assign o_wr_addr      = r_wr_addr;
    assign o_wr_data      = r_wr_data;
    assign o_frame_err    = r_frame_err;

endmodule

// File: tb/tb_max7219_serial_rx.sv
// Scoreboard bench for max7219_serial_rx: directed frames plus randomized frames against a register-file model.
module tb_max7219_serial_rx;

    localparam int SYNC = 2;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_serial_clk;
    logic        i_serial_dout;
    logic        i_serial_load;
    logic [63:0] o_digits;
    logic [7:0]  o_decode_mode;
    logic [3:0]  o_intensity;
    logic [2:0]  o_scan_limit;
    logic        o_shutdown_n;
    logic        o_display_test;
    logic        o_wr_valid;
    logic [3:0]  o_wr_addr;
    logic [7:0]  o_wr_data;
    logic        o_frame_err;

    max7219_serial_rx #(.SYNC_STAGES(SYNC), .FRAME_BITS(16)) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_serial_clk   (i_serial_clk),
        .i_serial_dout  (i_serial_dout),
        .i_serial_load  (i_serial_load),
        .o_digits       (o_digits),
        .o_decode_mode  (o_decode_mode),
        .o_intensity    (o_intensity),
        .o_scan_limit   (o_scan_limit),
        .o_shutdown_n   (o_shutdown_n),
        .o_display_test (o_display_test),
        .o_wr_valid     (o_wr_valid),
        .o_wr_addr      (o_wr_addr),
        .o_wr_data      (o_wr_data),
        .o_frame_err    (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [63:0] digits;
        logic [7:0]  decode;
        logic [3:0]  intensity;
        logic [2:0]  scan;
        logic        shdn;
        logic        test;
    } snap_t;

    typedef struct packed {
        logic        is_err;
        logic [3:0]  addr;
        logic [7:0]  data;
        snap_t       regs;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference register file
    logic [7:0] m_dig [8];
    logic [7:0] m_decode;
    logic [3:0] m_int;
    logic [2:0] m_scan;
    logic       m_shdn;
    logic       m_test;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 8; n++) m_dig[n] = 8'h00;
        m_decode = 8'h00; m_int = 4'h0; m_scan = 3'h0; m_shdn = 1'b0; m_test = 1'b0;
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        for (int n = 0; n < 8; n++) s.digits[8*n +: 8] = m_dig[n];
        s.decode = m_decode; s.intensity = m_int; s.scan = m_scan;
        s.shdn = m_shdn; s.test = m_test;
        return s;
    endfunction

    task automatic model_write(input logic [3:0] a, input logic [7:0] d);
        int ai;
        ai = int'(a);
        if (ai >= 1 && ai <= 8) m_dig[ai-1] = d;
        else if (ai == 9)  m_decode = d;
        else if (ai == 10) m_int = d[3:0];
        else if (ai == 11) m_scan = d[2:0];
        else if (ai == 12) m_shdn = d[0];
        else if (ai == 15) m_test = d[0];
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic start_frame();
        i_serial_load = 1'b0;
        wait_clk(4);
    endtask

    // Send nbits of 'bits' MSB first, sck = clk/8, data changed while sck low.
    task automatic shift_bits(input logic [31:0] bits, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            i_serial_clk  = 1'b0;
            i_serial_dout = bits[i];
            wait_clk(4);
            i_serial_clk = 1'b1;
            wait_clk(4);
        end
        i_serial_clk = 1'b0;
    endtask

    // Predict the outcome of the frame, then raise load.
    task automatic end_frame(input logic [31:0] bits, input int nbits);
        exp_t e;
        logic [15:0] last16;
        wait_clk(2);
        e = '0;
        if (nbits >= 16) begin
            last16 = bits[15:0];
            e.is_err = 1'b0;
            e.addr = last16[11:8];
            e.data = last16[7:0];
            model_write(e.addr, e.data);
        end else begin
            e.is_err = 1'b1;
        end
        e.regs = model_snap();
        q.push_back(e);
        i_serial_load = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] bits, input int nbits, input int hold);
        start_frame();
        shift_bits(bits, nbits);
        end_frame(bits, nbits);
        wait_clk(hold);
    endtask

    // Monitor: pop an expectation each time the DUT reports a commit or an error.
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (o_wr_valid === 1'b1 || o_frame_err === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", {62'd0, o_wr_valid, o_frame_err}, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("kind_valid", 64'(o_wr_valid), 64'(!e.is_err));
                    chk("kind_err", 64'(o_frame_err), 64'(e.is_err));
                    if (!e.is_err) begin
                        chk("wr_addr", 64'(o_wr_addr), 64'(e.addr));
                        chk("wr_data", 64'(o_wr_data), 64'(e.data));
                    end
                    chk("digits", o_digits, e.regs.digits);
                    chk("ctrl", {45'd0, o_decode_mode, o_intensity, o_scan_limit, o_shutdown_n, o_display_test},
                        {45'd0, e.regs.decode, e.regs.intensity, e.regs.scan, e.regs.shdn, e.regs.test});
                end
            end
        end
    end

    initial begin
        int n;
        int hold;
        logic [31:0] bits;

        i_reset_n = 1'b0; i_serial_clk = 1'b0; i_serial_dout = 1'b0; i_serial_load = 1'b0;
        model_reset();
        wait_clk(2);
        @(posedge i_clk); #1;
        chk("rst_digits", o_digits, 64'd0);
        chk("rst_ctrl", {45'd0, o_decode_mode, o_intensity, o_scan_limit, o_shutdown_n, o_display_test}, 64'd0);
        chk("rst_strobes", {62'd0, o_wr_valid, o_frame_err}, 64'd0);
        wait_clk(1);
        i_reset_n = 1'b1;
        wait_clk(3);

        // Shutdown frame with latency check relative to the first edge that samples load high.
        start_frame();
        shift_bits(32'h0000_0C01, 16);
        end_frame(32'h0000_0C01, 16);
        @(posedge i_clk);
        for (int k = 1; k <= SYNC; k++) begin
            @(posedge i_clk); #1;
            chk("latency_early", 64'(o_shutdown_n), 64'd0);
        end
        @(posedge i_clk); #1;
        chk("latency_on_time", 64'(o_shutdown_n), 64'd1);
        wait_clk(3);

        // Digit and intensity writes.
        send_frame(32'h0000_0112, 16, 3);
        send_frame(32'h0000_08A5, 16, 2);
        send_frame(32'h0000_0A3F, 16, 6);
        chk("digits_dir", o_digits, 64'hA500_0000_0000_0012);
        chk("intensity_dir", 64'(o_intensity), 64'hF);

        // Short frame, long frame, ignored address.
        send_frame(32'h0000_0B05, 12, 6);
        chk("short_no_change", 64'(o_scan_limit), 64'd0);
        send_frame(32'h000F_0B07, 20, 6);
        chk("long_scan", 64'(o_scan_limit), 64'd7);
        send_frame(32'h0000_0D55, 16, 6);

        // sck activity while load is high must not produce anything.
        for (int k = 0; k < 4; k++) begin
            i_serial_dout = 1'($urandom);
            i_serial_clk = 1'b1; wait_clk(4);
            i_serial_clk = 1'b0; wait_clk(4);
        end

        // Reset mid-frame: first 8 bits lost, the remaining 8 form a short frame.
        start_frame();
        shift_bits(32'h0000_0C00, 16'd8);
        i_reset_n = 1'b0;
        wait_clk(2);
        i_reset_n = 1'b1;
        model_reset();
        @(posedge i_clk); #1;
        chk("midreset_shutdown", 64'(o_shutdown_n), 64'd0);
        chk("midreset_digits", o_digits, 64'd0);
        wait_clk(1);
        shift_bits(32'h0000_0001, 8);
        end_frame(32'h0000_0001, 8);
        wait_clk(6);
        send_frame(32'h0000_0F01, 16, 6);
        chk("display_test", 64'(o_display_test), 64'd1);

        // Randomized frames: mostly full length, some short or long.
        for (int f = 0; f < 40; f++) begin
            bits = $urandom;
            n = $urandom_range(0, 9);
            if (n == 0)      n = $urandom_range(0, 15);
            else if (n == 1) n = $urandom_range(17, 24);
            else             n = 16;
            hold = $urandom_range(2, 6);
            send_frame(bits, n, hold);
        end

        // Drain the scoreboard with a bounded wait.
        for (int t = 0; t < 30 && q.size() != 0; t++) wait_clk(1);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
